proj_lane_sched: RTL and testbench

PROJ_LANE_SCHED -- requirements
Module: proj_lane_sched

---
 rtl/proj_lane_sched.sv | 145 ++++++++++++++
 tb/tb_proj_lane_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_lane_sched.sv
// Sequential lane test scheduler: enables one lane at a time, masks errors while it
// settles, latches synchronized checker errors during its dwell window, counts passes.
module proj_lane_sched #(
    parameter int unsigned LW     = 8,
    parameter int unsigned DWELL  = 1024,
    parameter int unsigned SETTLE = 16,
    parameter bit          LOOP   = 1'b1,
    localparam int unsigned CW    = (LW > 1) ? $clog2(LW) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] errflgs,
    output logic [LW-1:0] laneen,
    output logic [CW-1:0] curlane,
    output logic [LW-1:0] errsticky,
    output logic          busy,
    output logic          done,
    output logic [15:0]   passcnt
);

    localparam int unsigned MAXC = (DWELL > SETTLE) ? DWELL : SETTLE;
    localparam int unsigned CNTW = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic [CW-1:0]   curlane_d;
    logic [LW-1:0]   sticky_d;
    logic [15:0]     passcnt_d;
    logic [LW-1:0]   laneen_d;
    logic            busy_d;
    logic            done_d;
    logic [LW-1:0]   err_meta;
    logic [LW-1:0]   err_sync;

    // Two-flop synchronizer for the asynchronous checker flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_meta <= '0;
            err_sync <= '0;
        end else begin
            err_meta <= errflgs;
            err_sync <= err_meta;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNTW'(1);
        curlane_d = curlane;
        sticky_d  = errsticky;
        passcnt_d = passcnt;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_d = '0;
                if (start) begin
                    state_d   = ST_SETTLE;
                    curlane_d = '0;
                    sticky_d  = '0;
                    passcnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNTW'(SETTLE - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (err_sync[curlane]) begin
                    sticky_d[curlane] = 1'b1;
                end
                if (cnt_q == CNTW'(DWELL - 1)) begin
                    state_d = ST_NEXT;
                    cnt_d   = '0;
                end
            end
            ST_NEXT: begin
                cnt_d = '0;
                if (curlane == CW'(LW - 1)) begin
                    if (passcnt != 16'hFFFF) begin
                        passcnt_d = passcnt + 16'd1;
                    end
                    if (LOOP) begin
                        curlane_d = '0;
                        state_d   = ST_SETTLE;
                    end else begin
                        state_d   = ST_DONE;
                    end
                end else begin
                    curlane_d = curlane + CW'(1);
                    state_d   = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so the registers line up with it
        laneen_d = '0;
        if (state_d == ST_SETTLE || state_d == ST_RUN) begin
            laneen_d = LW'(1) << curlane_d;
        end
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_RUN) || (state_d == ST_NEXT);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            curlane   <= '0;
            errsticky <= '0;
            passcnt   <= '0;
            laneen    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            curlane   <= curlane_d;
            errsticky <= sticky_d;
            passcnt   <= passcnt_d;
            laneen    <= laneen_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_proj_lane_sched.sv
// Bench for proj_lane_sched with LW=4, DWELL=8, SETTLE=2: one single-pass and one looping instance.
module tb_proj_lane_sched;

    localparam int unsigned LW     = 4;
    localparam int unsigned DWELL  = 8;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned PER    = SETTLE + DWELL + 1;
    localparam int unsigned PASS   = LW * PER;

    typedef struct packed {
        logic [3:0] laneen;
        logic [1:0] curlane;
        logic       busy;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [3:0]  errflgs = '0;

    logic [3:0]  laneen0, errsticky0, laneen1, errsticky1;
    logic [1:0]  curlane0, curlane1;
    logic        busy0, done0, busy1, done1;
    logic [15:0] passcnt0, passcnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0       = 0;
    exp_t sb[$];

    proj_lane_sched #(.LW(LW), .DWELL(DWELL), .SETTLE(SETTLE), .LOOP(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .errflgs(errflgs),
        .laneen(laneen0), .curlane(curlane0), .errsticky(errsticky0),
        .busy(busy0), .done(done0), .passcnt(passcnt0)
    );

    proj_lane_sched #(.LW(LW), .DWELL(DWELL), .SETTLE(SETTLE), .LOOP(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .errflgs(errflgs),
        .laneen(laneen1), .curlane(curlane1), .errsticky(errsticky1),
        .busy(busy1), .done(done1), .passcnt(passcnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Park on the falling edge inside cycle k after the start edge (cycle 1 follows it)
    task automatic at_cycle(input int k);
        int tgt;
        tgt = e0 + k - 1;
        if (cyc > tgt) begin
            n_checks++;
            n_fail++;
            $display("FAIL at_cycle: target cycle %0d already passed (now %0d)", k, cyc - e0 + 1);
        end
        while (cyc < tgt) @(negedge clk);
    endtask

    task automatic do_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1;
        else       start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        e0 = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 12;
        if (laneen0 !== 4'b0)     begin n_fail++; $display("FAIL rst_laneen0 got %b want 0000", laneen0); end
        if (curlane0 !== 2'd0)    begin n_fail++; $display("FAIL rst_curlane0 got %0d want 0", curlane0); end
        if (errsticky0 !== 4'b0)  begin n_fail++; $display("FAIL rst_sticky0 got %b want 0000", errsticky0); end
        if (busy0 !== 1'b0)       begin n_fail++; $display("FAIL rst_busy0 got %b want 0", busy0); end
        if (done0 !== 1'b0)       begin n_fail++; $display("FAIL rst_done0 got %b want 0", done0); end
        if (passcnt0 !== 16'd0)   begin n_fail++; $display("FAIL rst_passcnt0 got %h want 0000", passcnt0); end
        if (laneen1 !== 4'b0)     begin n_fail++; $display("FAIL rst_laneen1 got %b want 0000", laneen1); end
        if (curlane1 !== 2'd0)    begin n_fail++; $display("FAIL rst_curlane1 got %0d want 0", curlane1); end
        if (errsticky1 !== 4'b0)  begin n_fail++; $display("FAIL rst_sticky1 got %b want 0000", errsticky1); end
        if (busy1 !== 1'b0)       begin n_fail++; $display("FAIL rst_busy1 got %b want 0", busy1); end
        if (done1 !== 1'b0)       begin n_fail++; $display("FAIL rst_done1 got %b want 0", done1); end
        if (passcnt1 !== 16'd0)   begin n_fail++; $display("FAIL rst_passcnt1 got %h want 0000", passcnt1); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || laneen0 !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_rst busy=%b laneen=%b want 0/0000", busy0, laneen0);
        end
    endtask

    // Per-cycle expected trace of one pass pushed at start, popped as the DUT runs
    task automatic test_single_pass;
        exp_t e, got;
        int lane, pos;
        do_start(1'b0);
        for (int k = 1; k <= int'(PASS); k++) begin
            lane = (k - 1) / int'(PER);
            pos  = (k - 1) % int'(PER);
            e.laneen  = (pos < int'(SETTLE + DWELL)) ? (4'b0001 << lane) : 4'b0000;
            e.curlane = 2'(lane);
            e.busy    = 1'b1;
            e.done    = 1'b0;
            sb.push_back(e);
        end
        for (int k = 1; k <= int'(PASS); k++) begin
            at_cycle(k);
            e   = sb.pop_front();
            got = '{laneen: laneen0, curlane: curlane0, busy: busy0, done: done0};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pass_trace cyc%0d got lane=%b cur=%0d busy=%b done=%b want lane=%b cur=%0d busy=%b done=%b",
                         k, got.laneen, got.curlane, got.busy, got.done, e.laneen, e.curlane, e.busy, e.done);
            end
        end
        at_cycle(PASS + 1);
        n_checks += 5;
        if (done0 !== 1'b1)      begin n_fail++; $display("FAIL pass_done got %b want 1", done0); end
        if (busy0 !== 1'b0)      begin n_fail++; $display("FAIL pass_busy got %b want 0", busy0); end
        if (passcnt0 !== 16'd1)  begin n_fail++; $display("FAIL pass_cnt got %0d want 1", passcnt0); end
        if (errsticky0 !== 4'b0) begin n_fail++; $display("FAIL pass_sticky got %b want 0000", errsticky0); end
        if (laneen0 !== 4'b0)    begin n_fail++; $display("FAIL pass_laneen got %b want 0000", laneen0); end
    endtask

    task automatic test_sticky_lane2;
        errflgs = 4'b0100;
        do_start(1'b0);
        at_cycle(2 * PER + SETTLE + 1);
        n_checks++;
        if (errsticky0 !== 4'b0000) begin n_fail++; $display("FAIL hold_pre_run got %b want 0000", errsticky0); end
        at_cycle(3 * PER + 1);
        n_checks++;
        if (errsticky0 !== 4'b0100) begin n_fail++; $display("FAIL hold_lane2 got %b want 0100", errsticky0); end
        at_cycle(PASS + 1);
        n_checks += 2;
        if (errsticky0 !== 4'b0100) begin n_fail++; $display("FAIL hold_end got %b want 0100", errsticky0); end
        if (done0 !== 1'b1)         begin n_fail++; $display("FAIL hold_done got %b want 1", done0); end
        errflgs = 4'b0000;
    endtask

    task automatic test_err_pulse;
        // pulse sampled by the first sync flop at edge 10 lands in lane-1 settle
        do_start(1'b0);
        at_cycle(1);
        n_checks += 2;
        if (errsticky0 !== 4'b0) begin n_fail++; $display("FAIL restart_sticky got %b want 0000", errsticky0); end
        if (done0 !== 1'b0)      begin n_fail++; $display("FAIL restart_done got %b want 0", done0); end
        at_cycle(PER - 1);
        errflgs = 4'b0010;
        at_cycle(PER);
        errflgs = 4'b0000;
        at_cycle(PASS + 1);
        n_checks++;
        if (errsticky0 !== 4'b0000) begin n_fail++; $display("FAIL settle_pulse got %b want 0000", errsticky0); end
        // pulse sampled at edge 19 is visible synchronized on lane-1's last run cycle
        do_start(1'b0);
        at_cycle(2 * PER - 3);
        errflgs = 4'b0010;
        at_cycle(2 * PER - 2);
        errflgs = 4'b0000;
        at_cycle(2 * PER + 1);
        n_checks++;
        if (errsticky0 !== 4'b0010) begin n_fail++; $display("FAIL last_run_pulse got %b want 0010", errsticky0); end
        at_cycle(PASS + 1);
        n_checks++;
        if (errsticky0 !== 4'b0010) begin n_fail++; $display("FAIL last_run_end got %b want 0010", errsticky0); end
    endtask

    task automatic test_loop;
        do_start(1'b1);
        at_cycle(30);
        start1 = 1'b1;
        at_cycle(31);
        start1 = 1'b0;
        at_cycle(PASS + 1);
        n_checks += 3;
        if (laneen1 !== 4'b0001) begin n_fail++; $display("FAIL loop_wrap_laneen got %b want 0001", laneen1); end
        if (passcnt1 !== 16'd1)  begin n_fail++; $display("FAIL loop_pass1 got %0d want 1", passcnt1); end
        if (done1 !== 1'b0)      begin n_fail++; $display("FAIL loop_done1 got %b want 0", done1); end
        at_cycle(70);
        start1 = 1'b1;
        at_cycle(71);
        start1 = 1'b0;
        at_cycle(3 * PASS + 1);
        n_checks += 4;
        if (passcnt1 !== 16'd3) begin n_fail++; $display("FAIL loop_pass3 got %0d want 3", passcnt1); end
        if (done1 !== 1'b0)     begin n_fail++; $display("FAIL loop_done3 got %b want 0", done1); end
        if (busy1 !== 1'b1)     begin n_fail++; $display("FAIL loop_busy got %b want 1", busy1); end
        if (curlane1 !== 2'd0)  begin n_fail++; $display("FAIL loop_curlane got %0d want 0", curlane1); end
    endtask

    task automatic test_saturate;
        at_cycle(3 * PASS + 2);
        force u1.passcnt = 16'hFFFE;
        at_cycle(3 * PASS + 3);
        release u1.passcnt;
        at_cycle(4 * PASS + 1);
        n_checks++;
        if (passcnt1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_first got %h want FFFF", passcnt1); end
        at_cycle(5 * PASS + 1);
        n_checks += 2;
        if (passcnt1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want FFFF", passcnt1); end
        if (done1 !== 1'b0)        begin n_fail++; $display("FAIL sat_done got %b want 0", done1); end
    endtask

    task automatic test_reset_midrun;
        do_start(1'b0);
        at_cycle(2 * PER + SETTLE + 3);
        n_checks++;
        if (laneen0 !== 4'b0100) begin n_fail++; $display("FAIL mid_lane2 got %b want 0100", laneen0); end
        #2 rst = 1'b0;
        #1;
        n_checks += 6;
        if (laneen0 !== 4'b0)     begin n_fail++; $display("FAIL mid_rst_laneen got %b want 0000", laneen0); end
        if (curlane0 !== 2'd0)    begin n_fail++; $display("FAIL mid_rst_curlane got %0d want 0", curlane0); end
        if (busy0 !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy0); end
        if (done0 !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_done got %b want 0", done0); end
        if (errsticky0 !== 4'b0)  begin n_fail++; $display("FAIL mid_rst_sticky got %b want 0000", errsticky0); end
        if (passcnt0 !== 16'd0)   begin n_fail++; $display("FAIL mid_rst_passcnt got %h want 0000", passcnt0); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (laneen0 !== 4'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst_idle i=%0d laneen=%b busy=%b want 0000/0", i, laneen0, busy0);
            end
        end
        do_start(1'b0);
        at_cycle(1);
        n_checks++;
        if (laneen0 !== 4'b0001) begin n_fail++; $display("FAIL post_rst_start got %b want 0001", laneen0); end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_sticky_lane2();
        test_err_pulse();
        test_loop();
        test_saturate();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
